// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register: 2-entry skid buffer with valid/ready handshake and flush.
// Optional saturating stall counter enabled by defining IFID_STALL_CNT_EN.
module if_id_pipe_reg #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [INST_W-1:0] in_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   input  logic              flush,
   output logic [1:0]        occupancy
`ifdef IFID_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t              state_reg;
   logic                out_valid_reg;
   logic                in_ready_reg;
   logic [PC_W-1:0]     head_pc_reg;
   logic [INST_W-1:0]   head_inst_reg;
   logic [PC_W-1:0]     skid_pc_reg;
   logic [INST_W-1:0]   skid_inst_reg;

   logic accept;
   logic pop;

   assign accept = in_valid & in_ready_reg;
   assign pop    = out_valid_reg & out_ready;

   // Occupancy and in_ready are both registered, so upstream sees no path from out_ready.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= EMPTY;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
         head_pc_reg   <= '0;
         head_inst_reg <= '0;
         skid_pc_reg   <= '0;
         skid_inst_reg <= '0;
      end else if (flush) begin
         state_reg     <= EMPTY;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (accept) begin
                  head_pc_reg   <= in_pc;
                  head_inst_reg <= in_inst;
                  out_valid_reg <= 1'b1;
                  state_reg     <= ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  head_pc_reg   <= in_pc;
                  head_inst_reg <= in_inst;
               end else if (accept) begin
                  skid_pc_reg   <= in_pc;
                  skid_inst_reg <= in_inst;
                  state_reg     <= FULL;
                  in_ready_reg  <= 1'b0;
               end else if (pop) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head_pc_reg   <= skid_pc_reg;
                  head_inst_reg <= skid_inst_reg;
                  state_reg     <= ONE;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg     <= EMPTY;
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_pc    = head_pc_reg;
   assign out_inst  = head_inst_reg;
   assign occupancy = state_reg;

`ifdef IFID_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_reg;

   // Saturating; flush deliberately leaves it alone.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
      end else if (out_valid_reg && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg: driver pushes expected entries on accept,
// a negedge monitor pops and compares on every pop.
module tb_if_id_pipe_reg;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        flush;
   logic [1:0]  occupancy;
`ifdef IFID_STALL_CNT_EN
   logic [3:0]  stall_cnt;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t exp_q[$];

   if_id_pipe_reg #(.PC_W(32), .INST_W(32), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .flush     (flush),
      .occupancy (occupancy)
`ifdef IFID_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
         $display("check %s: got 0x%0h expected 0x%0h ok", name, act, exp);
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: a pop happens at the next posedge whenever out_valid & out_ready here.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL spurious_pop: got pc 0x%0h inst 0x%0h expected no output", out_pc, out_inst);
         end else begin
            entry_t e;
            e = exp_q.pop_front();
            chk("pop_pc", out_pc, e.pc);
            chk("pop_inst", out_inst, e.inst);
         end
      end
   end

   // One clock of stimulus; inputs change 1 time unit after the posedge.
   task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic fl);
      entry_t e;
      in_valid  = v;
      in_pc     = pc;
      in_inst   = inst;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      #1;
      if (!rst_n) begin
         exp_q.delete();
      end else if (fl) begin
         exp_q.delete();
      end else if (in_valid && in_ready) begin
         e.pc   = pc;
         e.inst = inst;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
      out_ready = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      rst_n = 1'b1;

      // Streaming with decode always ready
      cyc(1'b1, 32'h100, 32'hA, 1'b1, 1'b0);
      chk("stream_first_pc", out_pc, 32'h100);
      chk("stream_occ1", 32'(occupancy), 32'd1);
      cyc(1'b1, 32'h104, 32'hB, 1'b1, 1'b0);
      chk("stream_occ2", 32'(occupancy), 32'd1);
      cyc(1'b1, 32'h108, 32'hC, 1'b1, 1'b0);
      chk("stream_occ3", 32'(occupancy), 32'd1);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("stream_drained_occ", 32'(occupancy), 32'd0);
      chk("stream_drained_valid", 32'(out_valid), 32'd0);

      // Fill while decode stalls, then drain
      cyc(1'b1, 32'h200, 32'h20, 1'b0, 1'b0);
      chk("fill_in_ready_one", 32'(in_ready), 32'd1);
      cyc(1'b1, 32'h204, 32'h21, 1'b0, 1'b0);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_occ", 32'(occupancy), 32'd2);
      chk("full_head_pc", out_pc, 32'h200);
      cyc(1'b1, 32'h2FF, 32'h2F, 1'b0, 1'b0);
      chk("full_ignore_occ", 32'(occupancy), 32'd2);
      chk("full_ignore_head", out_pc, 32'h200);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("drain_occ1", 32'(occupancy), 32'd1);
      chk("drain_in_ready", 32'(in_ready), 32'd1);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("drain_occ0", 32'(occupancy), 32'd0);

      // Flush while FULL with input offered
      cyc(1'b1, 32'h280, 32'h28, 1'b0, 1'b0);
      cyc(1'b1, 32'h284, 32'h29, 1'b0, 1'b0);
      cyc(1'b1, 32'h300, 32'h30, 1'b0, 1'b1);
      chk("flush_full_valid", 32'(out_valid), 32'd0);
      chk("flush_full_occ", 32'(occupancy), 32'd0);
      chk("flush_full_in_ready", 32'(in_ready), 32'd1);
      // Flush while empty drops the input accepted in that cycle
      cyc(1'b1, 32'h300, 32'h30, 1'b0, 1'b1);
      chk("flush_drop_valid", 32'(out_valid), 32'd0);
      chk("flush_drop_occ", 32'(occupancy), 32'd0);
      // A pop in the flush cycle still delivers its entry
      cyc(1'b1, 32'h310, 32'h31, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      chk("flush_pop_occ", 32'(occupancy), 32'd0);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("post_flush_valid", 32'(out_valid), 32'd0);

      // Reset mid-transfer while FULL with decode ready
      cyc(1'b1, 32'h400, 32'h40, 1'b0, 1'b0);
      cyc(1'b1, 32'h404, 32'h41, 1'b0, 1'b0);
      rst_n = 1'b0;
      cyc(1'b1, 32'h4FF, 32'h4F, 1'b1, 1'b0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_pc", out_pc, 32'd0);
      chk("midrst_inst", out_inst, 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_occ", 32'(occupancy), 32'd0);
`ifdef IFID_STALL_CNT_EN
      chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      rst_n = 1'b1;
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("postrst_valid", 32'(out_valid), 32'd0);

`ifdef IFID_STALL_CNT_EN
      // Stall counter saturation; flush must not clear it
      cyc(1'b1, 32'h500, 32'h50, 1'b0, 1'b0);
      chk("stall_start", 32'(stall_cnt), 32'd0);
      for (int i = 0; i < 20; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("stall_sat", 32'(stall_cnt), 32'd15);
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("stall_after_flush", 32'(stall_cnt), 32'd15);
`endif

      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
